uart_score_link: RTL

//  Two-player link between boards over a UART pin pair, 8N1 framing, LSB first.

---
 rtl/uart_score_link_if.sv | 23 ++
 rtl/uart_score_link.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_score_link_if.sv
// rtl/uart_score_link_if.sv - serial pins and game-event signals of uart_score_link
interface uart_score_link_if;
  logic       rx;
  logic       tx;
  logic       send_start;
  logic       send_score;
  logic [6:0] my_score;
  logic       uart_start;
  logic [6:0] op_score;
  logic       op_score_valid;
  logic       tx_busy;
  logic       frame_err;

  modport master (
    output rx, send_start, send_score, my_score,
    input  tx, uart_start, op_score, op_score_valid, tx_busy, frame_err
  );

  modport slave (
    input  rx, send_start, send_score, my_score,
    output tx, uart_start, op_score, op_score_valid, tx_busy, frame_err
  );
endinterface

// File: rtl/uart_score_link.sv
// rtl/uart_score_link.sv - START/score packet link over a UART pin pair; UART_PARITY_EN selects 8E1 framing
module uart_score_link #(
  parameter int CLK_HZ = 75_000_000,
  parameter int BAUD   = 115_200,
  parameter int OVS    = 16
) (
  input  logic             pclk,
  input  logic             rst,
  uart_score_link_if.slave link
);
  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [7:0] HDR_START = 8'h81;
  localparam logic [7:0] HDR_SCORE = 8'h82;
  localparam logic [6:0] SCORE_MAX = 7'd99;

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

`ifdef UART_PARITY_EN
  localparam tx_state_t TX_AFTER_DATA = T_PAR;
  localparam rx_state_t RX_AFTER_DATA = R_PAR;
`else
  localparam tx_state_t TX_AFTER_DATA = T_STOP;
  localparam rx_state_t RX_AFTER_DATA = R_STOP;
`endif

  logic          tick;
  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DW'(DIV - 1));

  // Baud-tick divider shared by both directions
  always_ff @(posedge pclk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  tx_state_t     tx_state, tx_next;
  logic [OW-1:0] tx_ovs;
  logic          tx_bit_end;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg, data_hold;
  logic [6:0]    score_hold;
  logic          start_pend, score_pend, data_pend;
  logic          take_start, take_score, take_data;
  logic          tx_par;
  logic          tx_line;

  // Free-running bit timer: bytes only launch on its boundary, so requests close together are arbitrated
  assign tx_bit_end = tick && (tx_ovs == OW'(OVS - 1));

  // TX state register
  always_ff @(posedge pclk) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_next;
  end

  // TX next state: score data byte follows its header, then START beats SCORE
  always_comb begin
    tx_next    = tx_state;
    take_start = 1'b0;
    take_score = 1'b0;
    take_data  = 1'b0;
    case (tx_state)
      T_IDLE, T_STOP: begin
        if (tx_bit_end) begin
          if (data_pend)       begin take_data  = 1'b1; tx_next = T_START; end
          else if (start_pend) begin take_start = 1'b1; tx_next = T_START; end
          else if (score_pend) begin take_score = 1'b1; tx_next = T_START; end
          else                 tx_next = T_IDLE;
        end
      end
      T_START: if (tx_bit_end) tx_next = T_DATA;
      T_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_AFTER_DATA;
`ifdef UART_PARITY_EN
      T_PAR:   if (tx_bit_end) tx_next = T_STOP;
`endif
      default: tx_next = T_IDLE;
    endcase
  end

  // TX request flags, score capture, bit timer, shift register and running parity
  always_ff @(posedge pclk) begin
    if (rst) begin
      start_pend <= 1'b0;
      score_pend <= 1'b0;
      data_pend  <= 1'b0;
      score_hold <= '0;
      data_hold  <= '0;
      tx_shreg   <= '0;
      tx_bit     <= '0;
      tx_ovs     <= '0;
      tx_par     <= 1'b0;
    end else begin
      start_pend <= (start_pend && !take_start) || link.send_start;
      score_pend <= (score_pend && !take_score) || link.send_score;
      data_pend  <= take_score || (data_pend && !take_data);
      if (link.send_score)
        score_hold <= (link.my_score > SCORE_MAX) ? SCORE_MAX : link.my_score;
      if (tick)
        tx_ovs <= (tx_ovs == OW'(OVS - 1)) ? '0 : tx_ovs + 1'b1;
      if (take_start || take_score || take_data) begin
        tx_bit <= '0;
        tx_par <= 1'b0;
      end else if (tx_state == T_DATA && tx_bit_end) begin
        tx_bit <= tx_bit + 1'b1;
        tx_par <= tx_par ^ tx_shreg[0];
      end
      if (take_start) begin
        tx_shreg <= HDR_START;
      end else if (take_score) begin
        tx_shreg  <= HDR_SCORE;
        data_hold <= {1'b0, score_hold};
      end else if (take_data) begin
        tx_shreg <= data_hold;
      end else if (tx_state == T_DATA && tx_bit_end) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
      end
    end
  end

  // Serial line level for the current TX state
  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      T_START: tx_line = 1'b0;
      T_DATA:  tx_line = tx_shreg[0];
`ifdef UART_PARITY_EN
      T_PAR:   tx_line = tx_par;
`endif
      default: tx_line = 1'b1;
    endcase
  end

  assign link.tx      = tx_line;
  assign link.tx_busy = (tx_state != T_IDLE) || start_pend || score_pend;

  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2;
  logic [OW-1:0] rx_ovs;
  logic          rx_mid, rx_sample;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;
  logic          rx_par_ok;
  logic          byte_valid, frame_err_q;

  assign rx_mid    = tick && (rx_ovs == OW'(OVS / 2 - 1));
  assign rx_sample = tick && (rx_ovs == OW'(OVS - 1));

`ifdef UART_PARITY_EN
  logic rx_par;
  assign rx_par_ok = (rx_par == ^rx_shreg);
`else
  assign rx_par_ok = 1'b1;
`endif

  // Two-flop synchronizer on the asynchronous rx pin
  always_ff @(posedge pclk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= link.rx;
      rx_s2 <= rx_s1;
    end
  end

  // RX state register
  always_ff @(posedge pclk) begin
    if (rst) rx_state <= R_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next state: start bit re-checked at half a bit, then sampling stays at mid-bit
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_s2) rx_next = R_START;
      R_START: if (rx_mid) rx_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_sample && rx_bit == 3'd7) rx_next = RX_AFTER_DATA;
`ifdef UART_PARITY_EN
      R_PAR:   if (rx_sample) rx_next = R_STOP;
`endif
      R_STOP:  if (rx_sample) rx_next = (rx_s2 && rx_par_ok) ? R_IDLE : R_WAIT;
      R_WAIT:  if (rx_s2) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  // RX bit timer, shift register and per-byte good/error strobes
  always_ff @(posedge pclk) begin
    if (rst) begin
      rx_ovs      <= '0;
      rx_bit      <= '0;
      rx_shreg    <= '0;
      byte_valid  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par      <= 1'b0;
`endif
    end else begin
      byte_valid  <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_state == R_IDLE || (rx_state == R_START && rx_mid))
        rx_ovs <= '0;
      else if (tick)
        rx_ovs <= (rx_ovs == OW'(OVS - 1)) ? '0 : rx_ovs + 1'b1;
      if (rx_state == R_START) begin
        rx_bit <= '0;
      end else if (rx_state == R_DATA && rx_sample) begin
        rx_bit   <= rx_bit + 1'b1;
        rx_shreg <= {rx_s2, rx_shreg[7:1]};
      end
`ifdef UART_PARITY_EN
      if (rx_state == R_PAR && rx_sample) rx_par <= rx_s2;
`endif
      if (rx_state == R_STOP && rx_sample) begin
        byte_valid  <= rx_s2 && rx_par_ok;
        frame_err_q <= !(rx_s2 && rx_par_ok);
      end
    end
  end

  logic       armed, uart_start_q, op_valid_q;
  logic [6:0] op_score_q;

  // Packet decoder: headers have bit7 set and always resync; data only counts after a SCORE header
  always_ff @(posedge pclk) begin
    if (rst) begin
      armed        <= 1'b0;
      uart_start_q <= 1'b0;
      op_valid_q   <= 1'b0;
      op_score_q   <= '0;
    end else begin
      uart_start_q <= 1'b0;
      if (byte_valid) begin
        if (rx_shreg[7]) begin
          armed <= (rx_shreg == HDR_SCORE);
          if (rx_shreg == HDR_START) begin
            uart_start_q <= 1'b1;
            op_valid_q   <= 1'b0;
          end
        end else if (armed) begin
          op_score_q <= rx_shreg[6:0];
          op_valid_q <= 1'b1;
          armed      <= 1'b0;
        end
      end
    end
  end

  assign link.uart_start     = uart_start_q;
  assign link.op_score       = op_score_q;
  assign link.op_score_valid = op_valid_q;
  assign link.frame_err      = frame_err_q;
endmodule
